// File: rtl/tinyqv_alu_seq.sv
// Nibble-serial ALU/shift/multiply sequencer: 8 RUN cycles plus one finalize cycle, then DONE.
// Build option: define TINYQV_ALU_SEQ_MUL_EN to include the multiplier and its accumulator.
module tinyqv_alu_seq #(
  parameter int MUL_B_BITS = 16
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start_valid,
  output logic        start_ready,
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res,
  output logic        cmp,
  output logic        busy
);
  // Handshake: a request transfers on a clock edge where start_valid && start_ready;
  // a result transfers where res_valid && res_ready. Each valid is held until its transfer.

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]  state;
  logic [3:0]  cnt;
  logic [3:0]  op_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic        carry;
  logic        cmp_chain;

  logic [4:0]  bit_base;
  logic [3:0]  a_nib;
  logic [3:0]  b_nib;
  logic        inv_b;
  logic [4:0]  add_sum;
  logic [31:0] sll_val;
  logic [31:0] srl_val;
  logic [31:0] sra_val;
  logic [3:0]  nib;
  logic        final_cmp;
  logic        is_slt;

  assign start_ready = (state == S_IDLE);
  assign res_valid   = (state == S_DONE);
  assign busy        = (state != S_IDLE);

  assign bit_base = {cnt[2:0], 2'b00};
  assign a_nib    = a_q[bit_base +: 4];
  assign b_nib    = b_q[bit_base +: 4];
  assign inv_b    = op_q[1] | op_q[3];
  assign add_sum  = {1'b0, a_nib} + {1'b0, inv_b ? ~b_nib : b_nib} + {4'b0000, carry};
  assign sll_val  = a_q << b_q[4:0];
  assign srl_val  = a_q >> b_q[4:0];
  assign sra_val  = $signed(a_q) >>> b_q[4:0];
  assign is_slt   = (op_q == 4'b0010) || (op_q == 4'b0011);

`ifdef TINYQV_ALU_SEQ_MUL_EN
  // acc carries everything above the nibble already emitted; a zero a_nib just shifts it down.
  logic [MUL_B_BITS:0]   acc;
  logic [MUL_B_BITS+4:0] mul_sum;
  assign mul_sum = {4'b0000, acc}
                 + ({{(MUL_B_BITS+1){1'b0}}, a_nib} * {5'b00000, b_q[MUL_B_BITS-1:0]});
`endif

  always_comb begin
    nib = 4'h0;
    case (op_q)
      4'b0000, 4'b1000: nib = add_sum[3:0];
      4'b0001:          nib = sll_val[bit_base +: 4];
      4'b0101:          nib = srl_val[bit_base +: 4];
      4'b1101:          nib = sra_val[bit_base +: 4];
      4'b0100:          nib = a_nib ^ b_nib;
      4'b0110:          nib = a_nib | b_nib;
      4'b0111:          nib = a_nib & b_nib;
`ifdef TINYQV_ALU_SEQ_MUL_EN
      4'b1010:          nib = mul_sum[3:0];
`endif
      default:          nib = 4'h0;
    endcase
  end

  // carry here is the carry-out of the top nibble; a signed compare folds in the sign bits.
  always_comb begin
    final_cmp = 1'b0;
    case (op_q)
      4'b0010: final_cmp = a_q[31] ^ ~b_q[31] ^ carry;
      4'b0011: final_cmp = ~carry;
      4'b0100: final_cmp = cmp_chain;
      default: final_cmp = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= S_IDLE;
      cnt       <= 4'd0;
      op_q      <= 4'd0;
      a_q       <= 32'd0;
      b_q       <= 32'd0;
      carry     <= 1'b0;
      cmp_chain <= 1'b0;
      res       <= 32'd0;
      cmp       <= 1'b0;
`ifdef TINYQV_ALU_SEQ_MUL_EN
      acc       <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start_valid) begin
            op_q      <= op;
            a_q       <= a;
            b_q       <= b;
            cnt       <= 4'd0;
            carry     <= op[1] | op[3];
            cmp_chain <= 1'b1;
            res       <= 32'd0;
`ifdef TINYQV_ALU_SEQ_MUL_EN
            acc       <= '0;
`endif
            state     <= S_RUN;
          end
        end
        S_RUN: begin
          if (cnt[3]) begin
            // Finalize cycle after the eighth nibble.
            cmp <= final_cmp;
            if (is_slt) res <= {31'd0, final_cmp};
            state <= S_DONE;
          end else begin
            res[bit_base +: 4] <= nib;
            carry     <= add_sum[4];
            cmp_chain <= cmp_chain & (a_nib == b_nib);
`ifdef TINYQV_ALU_SEQ_MUL_EN
            acc       <= mul_sum[MUL_B_BITS+4:4];
`endif
            cnt       <= cnt + 4'd1;
          end
        end
        S_DONE: begin
          if (res_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tinyqv_alu_seq.sv
// Bench for tinyqv_alu_seq: directed vectors, randomized ops against a reference model,
// handshake hold and mid-run reset.
module tb_tinyqv_alu_seq;
  logic        clk;
  logic        rstn;
  logic        start_valid;
  logic        start_ready;
  logic [3:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res;
  logic        cmp;
  logic        busy;

  int checks = 0;
  int errors = 0;
  logic [32:0] exp_q[$];

  tinyqv_alu_seq dut (
    .clk(clk), .rstn(rstn), .start_valid(start_valid), .start_ready(start_ready),
    .op(op), .a(a), .b(b), .res_valid(res_valid), .res_ready(res_ready),
    .res(res), .cmp(cmp), .busy(busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef TINYQV_ALU_SEQ_MUL_EN
  localparam logic [31:0] MUL_EXP = 32'h000369CF;
`else
  localparam logic [31:0] MUL_EXP = 32'h00000000;
`endif

  // reference model: {cmp, res} from plain arithmetic
  function automatic logic [32:0] model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [31:0] r;
    logic        c;
    r = 32'd0;
    c = 1'b0;
    case (o)
      4'b0000: r = x + y;
      4'b1000: r = x - y;
      4'b0010: begin c = ($signed(x) < $signed(y)); r = {31'd0, c}; end
      4'b0011: begin c = (x < y); r = {31'd0, c}; end
      4'b0100: begin r = x ^ y; c = (x == y); end
      4'b0110: r = x | y;
      4'b0111: r = x & y;
      4'b0001: r = x << y[4:0];
      4'b0101: r = x >> y[4:0];
      4'b1101: r = $signed(x) >>> y[4:0];
`ifdef TINYQV_ALU_SEQ_MUL_EN
      4'b1010: r = x * {16'd0, y[15:0]};
`endif
      default: r = 32'd0;
    endcase
    return {c, r};
  endfunction

  // driver: issue one op, scramble operands during RUN, wait for result, accept it
  task automatic do_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                       output logic [31:0] r, output logic c, output int lat);
    @(negedge clk);
    start_valid = 1'b1; op = o; a = x; b = y; res_ready = 1'b0;
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    op = 4'($urandom); a = $urandom; b = $urandom;
    lat = 0;
    while (!res_valid && lat < 30) begin
      @(posedge clk);
      #1;
      lat++;
    end
    r = res;
    c = cmp;
    @(negedge clk);
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0; start_valid = 1'b0; res_ready = 1'b0; op = 4'd0; a = 32'd0; b = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    checks++;
    if (res_valid !== 1'b0 || res !== 32'd0 || cmp !== 1'b0 || busy !== 1'b0 || start_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: res_valid=%b res=%h cmp=%b busy=%b start_ready=%b, want 0 0 0 0 1",
               res_valid, res, cmp, busy, start_ready);
    end
  endtask

  logic [3:0]  d_op  [14] = '{4'b0000, 4'b1000, 4'b0010, 4'b0011, 4'b0100, 4'b0111, 4'b0110,
                              4'b0001, 4'b0101, 4'b1101, 4'b1101, 4'b0001, 4'b1010, 4'b1001};
  logic [31:0] d_a   [14] = '{32'h0000FFFF, 32'h5, 32'h5, 32'hFFFFFFFF, 32'h12345678, 32'hF0F0F0F0,
                              32'hF0F0F0F0, 32'h80000010, 32'h80000010, 32'h80000010, 32'h80000010,
                              32'h80000010, 32'h00012345, 32'h12345678};
  logic [31:0] d_b   [14] = '{32'h1, 32'h7, 32'h7, 32'h1, 32'h12345678, 32'hFF00FF00, 32'hFF00FF00,
                              32'd4, 32'd4, 32'd4, 32'd31, 32'd0, 32'hFFFF0003, 32'h1};
  logic [31:0] d_res [14] = '{32'h00010000, 32'hFFFFFFFE, 32'h1, 32'h0, 32'h0, 32'hF000F000,
                              32'hFFF0FFF0, 32'h00000100, 32'h08000001, 32'hF8000001, 32'hFFFFFFFF,
                              32'h80000010, MUL_EXP, 32'h0};
  logic        d_cmp [14] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0,
                              1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

  task automatic test_directed();
    logic [31:0] r;
    logic        c;
    int          lat;
    for (int i = 0; i < 14; i++) begin
      do_op(d_op[i], d_a[i], d_b[i], r, c, lat);
      checks++;
      if (r !== d_res[i] || c !== d_cmp[i] || lat != 9) begin
        errors++;
        $display("FAIL directed_%0d op=%b: res=%h cmp=%b lat=%0d, want res=%h cmp=%b lat=9",
                 i, d_op[i], r, c, lat, d_res[i], d_cmp[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] r, x, y;
    logic        c;
    logic [3:0]  o;
    logic [32:0] e;
    int          lat;
    for (int i = 0; i < 60; i++) begin
      o = 4'($urandom_range(0, 15));
      x = $urandom;
      y = $urandom;
      if ($urandom_range(0, 3) == 0) y = x;
      exp_q.push_back(model(o, x, y));
      do_op(o, x, y, r, c, lat);
      e = exp_q.pop_front();
      checks++;
      if ({c, r} !== e || lat != 9) begin
        errors++;
        $display("FAIL random_%0d op=%b a=%h b=%h: res=%h cmp=%b lat=%0d, want res=%h cmp=%b lat=9",
                 i, o, x, y, r, c, lat, e[31:0], e[32]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] held;
    int          lat;
    @(negedge clk);
    start_valid = 1'b1; op = 4'b0000; a = 32'h11111111; b = 32'h22222222; res_ready = 1'b0;
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    lat = 0;
    while (!res_valid && lat < 30) begin
      @(posedge clk);
      #1;
      lat++;
    end
    held = res;
    checks++;
    if (lat != 9 || held !== 32'h33333333) begin
      errors++;
      $display("FAIL hold_first: res=%h lat=%0d, want 33333333 lat=9", held, lat);
    end
    // a competing request while the result waits must be ignored
    start_valid = 1'b1; op = 4'b1000; a = 32'h0; b = 32'h1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (res !== 32'h33333333 || res_valid !== 1'b1 || start_ready !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL hold_cycle_%0d: res=%h res_valid=%b start_ready=%b busy=%b, want 33333333 1 0 1",
                 i, res, res_valid, start_ready, busy);
      end
    end
    @(negedge clk);
    start_valid = 1'b0; res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    checks++;
    if (res_valid !== 1'b0 || res !== 32'h33333333 || start_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL hold_release: res_valid=%b res=%h start_ready=%b busy=%b, want 0 33333333 1 0",
               res_valid, res, start_ready, busy);
    end
  endtask

  task automatic test_reset_mid_run();
    logic [31:0] r;
    logic        c;
    int          lat;
    @(negedge clk);
    start_valid = 1'b1; op = 4'b0100; a = 32'hDEADBEEF; b = 32'hDEADBEEF; res_ready = 1'b0;
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rstn = 1'b0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    checks++;
    if (res_valid !== 1'b0 || res !== 32'd0 || cmp !== 1'b0 || busy !== 1'b0 || start_ready !== 1'b1) begin
      errors++;
      $display("FAIL midrun_reset: res_valid=%b res=%h cmp=%b busy=%b start_ready=%b, want 0 0 0 0 1",
               res_valid, res, cmp, busy, start_ready);
    end
    do_op(4'b0000, 32'h0000FFFF, 32'h00000001, r, c, lat);
    checks++;
    if (r !== 32'h00010000 || c !== 1'b0 || lat != 9) begin
      errors++;
      $display("FAIL after_reset_add: res=%h cmp=%b lat=%0d, want 00010000 0 9", r, c, lat);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
